// File: rtl/feature_mem_defs.sv
// Shared definitions for the feature memory responder: FSM encodings,
// default widths and the constant returned by out-of-range reads.
package feature_mem_defs;

  localparam int unsigned DEF_ADDRESS_BUS_BIT_WIDTH = 32;
  localparam int unsigned DEF_DATA_BIT_WIDTH        = 16;
  localparam int unsigned DEF_DEPTH                 = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_HOLD = 2'd1,
    ST_RD_HOLD = 2'd2
  } fsm_state_e;

  localparam logic [DEF_DATA_BIT_WIDTH-1:0] ZERO_DATA = '0;

endpackage : feature_mem_defs

// File: rtl/feature_word_ram.sv
// Single-port synchronous feature word store with write enable and a
// registered read port; the array itself is never reset.
module feature_word_ram #(
  parameter int unsigned DATA_BIT_WIDTH = 16,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned IDX_W          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic                      re_i,
  input  logic                      rd_zero_i,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic [DATA_BIT_WIDTH-1:0] wdata_i,
  output logic [DATA_BIT_WIDTH-1:0] rdata_o
);

  logic [DATA_BIT_WIDTH-1:0] mem [DEPTH];
  logic [DATA_BIT_WIDTH-1:0] rdata_q;
  logic [DATA_BIT_WIDTH-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[idx_i] <= wdata_i;
    end
  end

  // The read register holds its value between reads; rd_zero_i substitutes
  // an all-zero word so out-of-range reads never touch the array.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = rd_zero_i ? '0 : mem[idx_i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule : feature_word_ram

// File: rtl/feature_memory_responder.sv
// Responder for the two-cycle memory phase protocol. Optional sticky
// protocol checker is compiled in with FEATURE_MEM_PROTOCOL_CHECK_EN.
module feature_memory_responder
  import feature_mem_defs::*;
#(
  parameter int unsigned ADDRESS_BUS_BIT_WIDTH = DEF_ADDRESS_BUS_BIT_WIDTH,
  parameter int unsigned DATA_BIT_WIDTH        = DEF_DATA_BIT_WIDTH,
  parameter int unsigned DEPTH                 = DEF_DEPTH
) (
  input  logic                             clk,
  input  logic                             layer_reset,
  input  logic                             mem_wr_en_i,
  input  logic                             mem_rd_en_i,
  input  logic [ADDRESS_BUS_BIT_WIDTH-1:0] address_i,
  input  logic [DATA_BIT_WIDTH-1:0]        wr_data_i,
  output logic [DATA_BIT_WIDTH-1:0]        rd_data_o,
  output logic                             rd_data_valid_o,
  output logic                             protocol_error_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fsm_state_e                       state_q, state_d;
  logic [ADDRESS_BUS_BIT_WIDTH-1:0] addr_q, addr_d;
  logic                             valid_q, valid_d;
  logic                             addr_in_range;
  logic                             ram_we;
  logic                             ram_re;

  assign addr_in_range = (addr_q < ADDRESS_BUS_BIT_WIDTH'(DEPTH));

  // Write wins over read in IDLE; both hold states always return to IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_wr_en_i) begin
          addr_d  = address_i;
          state_d = ST_WR_HOLD;
        end else if (mem_rd_en_i) begin
          addr_d  = address_i;
          state_d = ST_RD_HOLD;
        end
      end
      ST_WR_HOLD: begin
        state_d = ST_IDLE;
        ram_we  = mem_wr_en_i & addr_in_range;
      end
      ST_RD_HOLD: begin
        state_d = ST_IDLE;
        ram_re  = mem_rd_en_i;
        valid_d = mem_rd_en_i;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge layer_reset) begin
    if (layer_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  feature_word_ram #(
    .DATA_BIT_WIDTH(DATA_BIT_WIDTH),
    .DEPTH         (DEPTH),
    .IDX_W         (IDX_W)
  ) u_ram (
    .clk      (clk),
    .rst      (layer_reset),
    .we_i     (ram_we),
    .re_i     (ram_re),
    .rd_zero_i(~addr_in_range),
    .idx_i    (addr_q[IDX_W-1:0]),
    .wdata_i  (wr_data_i),
    .rdata_o  (rd_data_o)
  );

  assign rd_data_valid_o = valid_q;

`ifdef FEATURE_MEM_PROTOCOL_CHECK_EN
  logic err_q, err_d;
  logic in_hold;
  logic hold_en;

  // Second-cycle checks apply only while the phase enable is still held.
  always_comb begin
    in_hold = (state_q == ST_WR_HOLD) || (state_q == ST_RD_HOLD);
    hold_en = ((state_q == ST_WR_HOLD) && mem_wr_en_i) ||
              ((state_q == ST_RD_HOLD) && mem_rd_en_i);
    err_d   = err_q;
    if (mem_wr_en_i && mem_rd_en_i) begin
      err_d = 1'b1;
    end
    if (in_hold && !hold_en) begin
      err_d = 1'b1;
    end
    if (hold_en && (address_i != addr_q)) begin
      err_d = 1'b1;
    end
    if (hold_en && !addr_in_range) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge layer_reset) begin
    if (layer_reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign protocol_error_o = err_q;
`else
  assign protocol_error_o = 1'b0;
`endif

endmodule : feature_memory_responder
